adc_capture_ctrl: RTL

//  Capture/trigger controller between the SYZYGY ADC deserializer outputs and the sample FIFO write port.

---
 rtl/adc_capture_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/adc_capture_ctrl.sv
// rtl/adc_capture_ctrl.sv - ADC capture/trigger controller feeding the sample FIFO write port (optional ADC_CAPTURE_DECIM_EN adds decimation)
module adc_capture_ctrl #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 24
) (
    input  logic                adc_data_clk,
    input  logic                reset,
    input  logic                arm,
    input  logic                abort,
    input  logic                force_trig,
    input  logic                trig_en,
    input  logic                trig_chan,
    input  logic                trig_rising,
    input  logic [DATA_W-1:0]   trig_level,
    input  logic [CNT_W-1:0]    capture_len,
    input  logic [DATA_W-1:0]   adc_data_1,
    input  logic [DATA_W-1:0]   adc_data_2,
    input  logic                adc_data_valid,
    input  logic                fifo_prog_full,
`ifdef ADC_CAPTURE_DECIM_EN
    input  logic [7:0]          decim,
`endif
    output logic [2*DATA_W-1:0] fifo_din,
    output logic                fifo_wr_en,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic [CNT_W-1:0]    sample_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    len_q, len_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CNT_W-1:0]    count_inc;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic                force_q, force_d;
    logic [2*DATA_W-1:0] din_q, din_d;
    logic                wr_en_q, wr_en_d;
`ifdef ADC_CAPTURE_DECIM_EN
    logic [7:0]          decim_cnt_q, decim_cnt_d;
`endif

    logic signed [DATA_W-1:0] sel_s;
    logic signed [DATA_W-1:0] prev_s;
    logic signed [DATA_W-1:0] level_s;
    logic                     crossing;
    logic                     consume;

    assign sel_s     = trig_chan ? adc_data_2 : adc_data_1;
    assign prev_s    = prev_q;
    assign level_s   = trig_level;
    assign count_inc = count_q + CNT_W'(1);

    // Level crossing needs a previous valid sample; the first one after arm only primes prev
    always_comb begin
        crossing = 1'b0;
        if (prev_valid_q) begin
            if (trig_rising) begin
                crossing = (prev_s < level_s) && (sel_s >= level_s);
            end else begin
                crossing = (prev_s > level_s) && (sel_s <= level_s);
            end
        end
    end

    // Next-state, trigger evaluation and sample consumption
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        count_d      = count_q;
        ovf_d        = ovf_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        force_d      = force_q;
        din_d        = din_q;
        wr_en_d      = 1'b0;
        consume      = 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
        decim_cnt_d  = decim_cnt_q;
`endif
        if (abort) begin
            state_d = IDLE;
            force_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (arm && (capture_len != '0)) begin
                        state_d      = ARMED;
                        len_d        = capture_len;
                        count_d      = '0;
                        ovf_d        = 1'b0;
                        prev_valid_d = 1'b0;
                        force_d      = 1'b0;
                    end
                end
                ARMED: begin
                    if (adc_data_valid) begin
                        prev_d       = sel_s;
                        prev_valid_d = 1'b1;
                        if (force_q || force_trig || !trig_en || crossing) begin
                            // The triggering sample is capture sample #1
                            state_d = CAPTURE;
                            force_d = 1'b0;
                            consume = 1'b1;
`ifdef ADC_CAPTURE_DECIM_EN
                            decim_cnt_d = decim;
`endif
                        end else if (force_trig) begin
                            force_d = 1'b1;
                        end
                    end else if (force_trig) begin
                        force_d = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (adc_data_valid) begin
`ifdef ADC_CAPTURE_DECIM_EN
                        if (decim_cnt_q == 8'd0) begin
                            consume     = 1'b1;
                            decim_cnt_d = decim;
                        end else begin
                            decim_cnt_d = decim_cnt_q - 8'd1;
                        end
`else
                        consume = 1'b1;
`endif
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Dropped samples still count so the capture window is fixed in samples
        if (consume) begin
            count_d = count_inc;
            if (!fifo_prog_full) begin
                din_d   = {adc_data_1, adc_data_2};
                wr_en_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
            if (count_inc == len_q) begin
                state_d = DONE;
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge adc_data_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            force_q      <= 1'b0;
            din_q        <= '0;
            wr_en_q      <= 1'b0;
`ifdef ADC_CAPTURE_DECIM_EN
            decim_cnt_q  <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            force_q      <= force_d;
            din_q        <= din_d;
            wr_en_q      <= wr_en_d;
`ifdef ADC_CAPTURE_DECIM_EN
            decim_cnt_q  <= decim_cnt_d;
`endif
        end
    end

    assign fifo_din     = din_q;
    assign fifo_wr_en   = wr_en_q;
    assign busy         = (state_q == ARMED) || (state_q == CAPTURE);
    assign done         = (state_q == DONE);
    assign overflow     = ovf_q;
    assign sample_count = count_q;

endmodule
